// File: rtl/apb_ram_slave_if.sv
// ---------------------------------------------------------------------------
// apb_ram_slave_if
// APB3 bus bundle between the AHB-to-APB bridge (master side) and one
// completer slot (slave side).
//   psel, penable, pwrite : slot select, access phase, direction
//   paddr                 : byte address (APB_ADDR_WIDTH bits)
//   pwdata, pstrb         : write data and byte strobes
//   prdata                : 8-bit read data back to the bridge
//   pready, pslverr       : completion handshake and error response
// ---------------------------------------------------------------------------
interface apb_ram_slave_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [3:0]                pstrb;
    logic [7:0]                prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_ram_slave.sv
// ---------------------------------------------------------------------------
// apb_ram_slave
// Byte-wide APB3 RAM completer ("ram1" slot of the AHB-to-APB bridge).
// Stores pwdata[7:0] when pstrb[0] is set, inserts WAIT_STATES pready-low
// access cycles before every completion and answers out-of-range byte
// offsets (>= DEPTH) with pslverr. A transfer always spans 2+WAIT_STATES
// pclk cycles: setup, WAIT_STATES wait cycles, completion.
// Ports:
//   pclk   : APB clock, all state changes on its rising edge
//   preset : asynchronous active-high reset (RAM contents are kept)
//   apb    : APB slave modport (psel/penable/pwrite/paddr/pwdata/pstrb in,
//            prdata/pready/pslverr out)
// ---------------------------------------------------------------------------
module apb_ram_slave #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int WAIT_STATES    = 1
) (
    input  logic           pclk,
    input  logic           preset,
    apb_ram_slave_if.slave apb
);
    localparam int                      IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]              WS      = 4'(WAIT_STATES);
    localparam logic [APB_ADDR_WIDTH:0] DEPTH_A = (APB_ADDR_WIDTH+1)'(DEPTH);

    // SETUP: the setup phase has been latched; the bus is now in its first
    //        access cycle (which is also the first wait cycle, if any).
    // ACCESS: later access cycles; cnt_q counts wait cycles already spent.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             write_q, write_d;
    logic             strb_q, strb_d;
    logic             err_q, err_d;
    logic [7:0]       data_q, data_d;
    logic             done;

    // Storage is intentionally not reset so contents survive preset.
    logic [7:0] mem [DEPTH];

    // Only the low data byte and strobe bit carry meaning for this slot.
    logic unused_bits;
    assign unused_bits = ^{apb.pwdata[DATA_WIDTH-1:8], apb.pstrb[3:1]};

    // State register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        strb_d  = strb_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                // penable=1 without a setup phase is ignored here.
                if (apb.psel && !apb.penable) begin
                    state_d = SETUP;
                    cnt_d   = 4'd0;
                    addr_d  = apb.paddr[IDX_W-1:0];
                    write_d = apb.pwrite;
                    strb_d  = apb.pstrb[0];
                    data_d  = apb.pwdata[7:0];
                    err_d   = ({1'b0, apb.paddr} >= DEPTH_A);
                end
            end
            SETUP: begin
                if (apb.psel && apb.penable) begin
                    if (WS == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Dropping psel aborts; reaching WS means this cycle completes.
                if (!apb.psel || cnt_q == WS) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: completion strobes are nonzero only in the completion cycle.
    always_comb begin
        done = 1'b0;
        case (state_q)
            SETUP:   done = apb.psel && apb.penable && (WS == 4'd0);
            ACCESS:  done = apb.psel && (cnt_q == WS);
            default: done = 1'b0;
        endcase
        apb.pready  = done;
        apb.pslverr = done && err_q;
        apb.prdata  = (done && !err_q) ? mem[addr_q] : 8'h00;
    end

    always_ff @(posedge pclk) begin
        if (done && write_q && strb_q && !err_q) begin
            mem[addr_q] <= data_q;
        end
    end
endmodule

// File: tb/tb_apb_ram_slave.sv
module tb_apb_ram_slave;
    logic        pclk;
    logic        preset;
    bit          tgt;        // 0 selects the zero-wait slot, 1 the one-wait slot
    logic        m_psel, m_penable, m_pwrite;
    logic [11:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rd;
    logic       er;
    int         cyc;
    bit         gl;

    // Reference model of both RAMs.
    logic [7:0] mm [2][1024];
    bit         kn [2][1024];

    apb_ram_slave_if #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    apb_ram_slave_if #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(32)) bus1 ();

    apb_ram_slave #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0))
        dut0 (.pclk(pclk), .preset(preset), .apb(bus0));
    apb_ram_slave #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1))
        dut1 (.pclk(pclk), .preset(preset), .apb(bus1));

    assign bus0.psel    = m_psel && !tgt;
    assign bus1.psel    = m_psel && tgt;
    assign bus0.penable = m_penable;
    assign bus1.penable = m_penable;
    assign bus0.pwrite  = m_pwrite;
    assign bus1.pwrite  = m_pwrite;
    assign bus0.paddr   = m_paddr;
    assign bus1.paddr   = m_paddr;
    assign bus0.pwdata  = m_pwdata;
    assign bus1.pwdata  = m_pwdata;
    assign bus0.pstrb   = m_pstrb;
    assign bus1.pstrb   = m_pstrb;

    logic       s_pready, s_pslverr;
    logic [7:0] s_prdata;
    assign s_pready  = tgt ? bus1.pready  : bus0.pready;
    assign s_pslverr = tgt ? bus1.pslverr : bus0.pslverr;
    assign s_prdata  = tgt ? bus1.prdata  : bus0.prdata;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One APB transfer, started right after a rising edge. Returns the
    // completion data, the total cycle count (-1 on timeout) and a flag for
    // any nonzero output outside the completion cycle.
    task automatic apb_xfer(input bit t, input bit wr, input logic [11:0] a,
                            input logic [31:0] wd, input logic [3:0] st, input bit corrupt,
                            output logic [7:0] o_rd, output logic o_er, output int o_cyc,
                            output bit o_gl);
        tgt = t; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
        m_paddr = a; m_pwdata = wd; m_pstrb = st;
        o_gl = 1'b0; o_cyc = -1; o_rd = 8'h00; o_er = 1'b0;
        @(negedge pclk);
        if (s_pready || s_pslverr || s_prdata != 8'h00) o_gl = 1'b1;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        if (corrupt) begin
            m_paddr = a ^ 12'h0F0; m_pwrite = ~wr; m_pwdata = ~wd;
        end
        for (int k = 1; k <= 40 && o_cyc < 0; k++) begin
            @(negedge pclk);
            if (s_pready) begin
                o_rd = s_prdata; o_er = s_pslverr; o_cyc = k + 1;
            end else if (s_pslverr || s_prdata != 8'h00) begin
                o_gl = 1'b1;
            end
            @(posedge pclk); #1;
        end
        m_psel = 1'b0; m_penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_checks++; if ({bus0.pready, bus0.pslverr, bus0.prdata} !== 10'h0) begin n_fail++; $display("FAIL reset_out0: got %h required 000", {bus0.pready, bus0.pslverr, bus0.prdata}); end
        n_checks++; if ({bus1.pready, bus1.pslverr, bus1.prdata} !== 10'h0) begin n_fail++; $display("FAIL reset_out1: got %h required 000", {bus1.pready, bus1.pslverr, bus1.prdata}); end
        @(posedge pclk); #1;
        preset = 1'b0;
    endtask

    task automatic test_ws1_write_read();
        apb_xfer(1, 1, 12'h010, 32'h1234_565A, 4'hF, 0, rd, er, cyc, gl);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL ws1_wr_cycles: got %0d required 3", cyc); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL ws1_wr_err: got %b required 0", er); end
        n_checks++; if (gl !== 1'b0) begin n_fail++; $display("FAIL ws1_wr_idle_outputs: got %b required 0", gl); end
        apb_xfer(1, 0, 12'h010, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL ws1_rd_cycles: got %0d required 3", cyc); end
        n_checks++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL ws1_rd_data: got %h required 5a", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL ws1_rd_err: got %b required 0", er); end
        n_checks++; if (gl !== 1'b0) begin n_fail++; $display("FAIL ws1_rd_idle_outputs: got %b required 0", gl); end
    endtask

    task automatic test_back_to_back();
        apb_xfer(0, 1, 12'h000, 32'hFFFF_FF11, 4'h1, 0, rd, er, cyc, gl);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_wr0_cycles: got %0d required 2", cyc); end
        apb_xfer(0, 1, 12'h3FF, 32'h0000_0022, 4'hF, 0, rd, er, cyc, gl);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_wr1_cycles: got %0d required 2", cyc); end
        apb_xfer(0, 0, 12'h000, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_rd0_cycles: got %0d required 2", cyc); end
        n_checks++; if (rd !== 8'h11) begin n_fail++; $display("FAIL b2b_rd0_data: got %h required 11", rd); end
        apb_xfer(0, 0, 12'h3FF, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_rd1_cycles: got %0d required 2", cyc); end
        n_checks++; if (rd !== 8'h22) begin n_fail++; $display("FAIL b2b_rd1_data: got %h required 22", rd); end
        n_checks++; if (gl !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_outputs: got %b required 0", gl); end
    endtask

    task automatic test_out_of_range();
        apb_xfer(0, 1, 12'h400, 32'h0000_00AA, 4'hF, 0, rd, er, cyc, gl);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b required 1", er); end
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_wr_data: got %h required 00", rd); end
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_wr_cycles: got %0d required 2", cyc); end
        apb_xfer(0, 0, 12'h400, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b required 1", er); end
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_rd_data: got %h required 00", rd); end
        apb_xfer(0, 0, 12'h000, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h11) begin n_fail++; $display("FAIL oor_rd_alias0: got %h required 11", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL oor_rd_alias0_err: got %b required 0", er); end
        apb_xfer(1, 0, 12'hFFF, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_ws1_err: got %b required 1", er); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL oor_ws1_cycles: got %0d required 3", cyc); end
        n_checks++; if (gl !== 1'b0) begin n_fail++; $display("FAIL oor_ws1_idle_outputs: got %b required 0", gl); end
    endtask

    task automatic test_strobe_off();
        apb_xfer(1, 1, 12'h010, 32'h0000_0077, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL strb_wr_err: got %b required 0", er); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL strb_wr_cycles: got %0d required 3", cyc); end
        apb_xfer(1, 1, 12'h010, 32'h0000_0078, 4'hE, 0, rd, er, cyc, gl);
        apb_xfer(1, 0, 12'h010, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL strb_rd_data: got %h required 5a", rd); end
    endtask

    task automatic test_abort();
        apb_xfer(1, 1, 12'h020, 32'h0000_0044, 4'hF, 0, rd, er, cyc, gl);
        // Setup for a write of EE, then psel falls in what would be the wait cycle.
        tgt = 1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 12'h020; m_pwdata = 32'h0000_00EE; m_pstrb = 4'hF;
        @(posedge pclk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge pclk);
            n_checks++; if ({bus1.pready, bus1.pslverr, bus1.prdata} !== 10'h0) begin n_fail++; $display("FAIL abort_outputs: got %h required 000", {bus1.pready, bus1.pslverr, bus1.prdata}); end
            @(posedge pclk); #1;
        end
        apb_xfer(1, 0, 12'h020, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h44) begin n_fail++; $display("FAIL abort_rd_data: got %h required 44", rd); end
    endtask

    task automatic test_penable_no_setup();
        tgt = 1; m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b1;
        m_paddr = 12'h020; m_pwdata = 32'h0000_00EE; m_pstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            n_checks++; if (bus1.pready !== 1'b0) begin n_fail++; $display("FAIL nosetup_pready: got %b required 0", bus1.pready); end
            @(posedge pclk); #1;
        end
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(1, 0, 12'h020, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h44) begin n_fail++; $display("FAIL nosetup_rd_data: got %h required 44", rd); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL nosetup_rd_cycles: got %0d required 3", cyc); end
    endtask

    task automatic test_latched();
        apb_xfer(1, 1, 12'h050, 32'h0000_0066, 4'hF, 1, rd, er, cyc, gl);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL latch_wr_cycles: got %0d required 3", cyc); end
        apb_xfer(1, 0, 12'h050, 32'h0000_0013, 4'hF, 1, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h66) begin n_fail++; $display("FAIL latch_rd_data: got %h required 66", rd); end
        apb_xfer(1, 0, 12'h050, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h66) begin n_fail++; $display("FAIL latch_rd_again: got %h required 66", rd); end
    endtask

    task automatic test_reset_mid_write();
        apb_xfer(1, 1, 12'h030, 32'h0000_0033, 4'h1, 0, rd, er, cyc, gl);
        tgt = 1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 12'h030; m_pwdata = 32'h0000_0099; m_pstrb = 4'hF;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        #2 preset = 1'b1;
        #1;
        n_checks++; if ({bus1.pready, bus1.pslverr, bus1.prdata} !== 10'h0) begin n_fail++; $display("FAIL rstmid_ws1_outputs: got %h required 000", {bus1.pready, bus1.pslverr, bus1.prdata}); end
        repeat (2) @(posedge pclk);
        #1;
        m_psel = 1'b0; m_penable = 1'b0; preset = 1'b0;
        apb_xfer(1, 0, 12'h030, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h33) begin n_fail++; $display("FAIL rstmid_ws1_rd_data: got %h required 33", rd); end

        // Reset landing in a completion cycle must clear pready at once.
        apb_xfer(0, 1, 12'h005, 32'h0000_0005, 4'h1, 0, rd, er, cyc, gl);
        tgt = 0; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 12'h005; m_pwdata = 32'h0000_0055; m_pstrb = 4'h1;
        @(posedge pclk); #1;
        m_penable = 1'b1;
        #2;
        n_checks++; if (bus0.pready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ws0_pready_before: got %b required 1", bus0.pready); end
        preset = 1'b1;
        #1;
        n_checks++; if ({bus0.pready, bus0.pslverr, bus0.prdata} !== 10'h0) begin n_fail++; $display("FAIL rstmid_ws0_outputs: got %h required 000", {bus0.pready, bus0.pslverr, bus0.prdata}); end
        @(posedge pclk); #1;
        m_psel = 1'b0; m_penable = 1'b0; preset = 1'b0;
        apb_xfer(0, 0, 12'h005, 32'h0, 4'h0, 0, rd, er, cyc, gl);
        n_checks++; if (rd !== 8'h05) begin n_fail++; $display("FAIL rstmid_ws0_rd_data: got %h required 05", rd); end
    endtask

    task automatic test_random();
        bit          t, wr, oor;
        logic [11:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [7:0]  exp_rd;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 1024; j++) kn[i][j] = 1'b0;
        for (int n = 0; n < 80; n++) begin
            t   = 1'($urandom_range(0, 1));
            oor = ($urandom_range(0, 7) == 0);
            a   = oor ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 1023));
            wr  = 1'($urandom_range(0, 1));
            if (!oor && !kn[t][a]) wr = 1'b1;
            wd  = $urandom;
            st  = 4'($urandom_range(0, 15));
            apb_xfer(t, wr, a, wd, st, 0, rd, er, cyc, gl);
            n_checks++; if (cyc !== 2 + int'(t)) begin n_fail++; $display("FAIL rnd_cycles[%0d]: got %0d required %0d", n, cyc, 2 + int'(t)); end
            n_checks++; if (er !== oor) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b required %b", n, er, oor); end
            n_checks++; if (gl !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_outputs[%0d]: got %b required 0", n, gl); end
            if (!wr) begin
                exp_rd = oor ? 8'h00 : mm[t][a[9:0]];
                n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rd_data[%0d]: got %h required %h", n, rd, exp_rd); end
            end else if (!oor && st[0]) begin
                mm[t][a[9:0]] = wd[7:0];
                kn[t][a[9:0]] = 1'b1;
            end
        end
    endtask

    initial begin
        preset = 1'b1; tgt = 1'b0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pstrb = '0;
        test_reset();
        test_ws1_write_read();
        test_back_to_back();
        test_out_of_range();
        test_strobe_off();
        test_abort();
        test_penable_no_setup();
        test_latched();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
